// File: rtl/sort_fifo_pkg.sv
// Shared constants and width helpers for the sorting-datapath FIFO.
// Build option: define SORT_FIFO_FWFT_EN for first-word-fall-through reads.
package sort_fifo_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefDepth = 16;

`ifdef SORT_FIFO_FWFT_EN
  localparam bit FwftEn = 1'b1;
`else
  localparam bit FwftEn = 1'b0;
`endif

  // Pointer and count width: one extra MSB separates full from empty.
  function automatic int unsigned ptr_w(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned addr_w(int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sort_sync_fifo_if.sv
// Write/read handshake bundle of the sorting FIFO; master is the user, slave is the FIFO.
interface sort_sync_fifo_if
  import sort_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth
);

  logic [DATA_W-1:0]       din;
  logic                    wr_en;
  logic                    full;
  logic                    rd_en;
  logic [DATA_W-1:0]       dout;
  logic                    empty;
  logic                    almost_full;
  logic                    almost_empty;
  logic [ptr_w(DEPTH)-1:0] count;
  logic                    overflow;
  logic                    underflow;

  modport master (
    output din, wr_en, rd_en,
    input  full, dout, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en,
    output full, dout, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/sort_fifo_ram.sv
// Simple dual-port storage array: synchronous write, registered synchronous read.
module sort_fifo_ram
  import sort_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we_i,
  input  logic [addr_w(DEPTH)-1:0]   waddr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic                       re_i,
  input  logic [addr_w(DEPTH)-1:0]   raddr_i,
  output logic [DATA_W-1:0]          rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage is never reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sort_sync_fifo.sv
// Single-clock FIFO with occupancy count, programmable almost flags and error pulses.
// Build option: SORT_FIFO_FWFT_EN selects first-word-fall-through reads.
module sort_sync_fifo
  import sort_fifo_pkg::*;
#(
  parameter int unsigned DATA_W          = DefDataW,
  parameter int unsigned DEPTH           = DefDepth,
  parameter int unsigned ALMOST_FULL_TH  = DEPTH - 2,
  parameter int unsigned ALMOST_EMPTY_TH = 2
) (
  input logic               clk,
  input logic               rst,
  sort_sync_fifo_if.slave   bus
);

  localparam int unsigned AW = addr_w(DEPTH);
  localparam int unsigned PW = ptr_w(DEPTH);

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;
  logic              wr_acc, rd_acc, ram_re;
  logic [AW-1:0]     ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    rd_acc      = bus.rd_en && !empty_q;
    wr_acc      = bus.wr_en && (!full_q || rd_acc);
    wr_ptr_d    = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d    = rd_ptr_q + PW'(rd_acc);
    count_d     = count_q + PW'(wr_acc) - PW'(rd_acc);
    full_d      = (count_d == PW'(DEPTH));
    empty_d     = (count_d == '0);
    overflow_d  = bus.wr_en && !wr_acc;
    underflow_d = bus.rd_en && !rd_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sort_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (bus.din),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

`ifdef SORT_FIFO_FWFT_EN
  // The RAM continuously pre-reads the next head slot. A write landing in that
  // same slot is captured separately since the RAM returns the old contents.
  logic              byp_q, byp_d;
  logic [DATA_W-1:0] byp_data_q, byp_data_d, last_q, last_d, head;

  assign ram_re    = 1'b1;
  assign ram_raddr = rd_ptr_d[AW-1:0];
  assign head      = byp_q ? byp_data_q : ram_rdata;

  always_comb begin
    byp_d      = wr_acc && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]);
    byp_data_d = bus.din;
    last_d     = rd_acc ? head : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_q      <= 1'b0;
      byp_data_q <= '0;
      last_q     <= '0;
    end else begin
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
      last_q     <= last_d;
    end
  end

  assign bus.dout = empty_q ? last_q : head;
`else
  assign ram_re    = rd_acc;
  assign ram_raddr = rd_ptr_q[AW-1:0];
  assign bus.dout  = ram_rdata;
`endif

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
  assign bus.almost_full  = (count_q >= PW'(ALMOST_FULL_TH));
  assign bus.almost_empty = (count_q <= PW'(ALMOST_EMPTY_TH));

endmodule

// File: tb/tb_sort_sync_fifo.sv
// Directed bench for sort_sync_fifo (DATA_W=32, DEPTH=16); covers both read modes.
module tb_sort_sync_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sort_sync_fifo_if #(.DATA_W(32), .DEPTH(16)) bus ();

  sort_sync_fifo #(
    .DATA_W (32),
    .DEPTH  (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] v);
    bus.din   = v;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b0;
    step();
    idle();
  endtask

  // Returns the word delivered by this read in either read mode.
  task automatic read_word(input logic wr, input logic [31:0] v, output logic [31:0] obs);
    bus.din   = v;
    bus.wr_en = wr;
    bus.rd_en = 1'b1;
`ifdef SORT_FIFO_FWFT_EN
    obs = bus.dout;
    step();
`else
    step();
    obs = bus.dout;
`endif
    idle();
  endtask

  task automatic test_reset();
    idle();
    bus.din = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.count !== 5'd0 ||
        bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0 ||
        bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: empty=%b full=%b count=%0d ae=%b af=%b ov=%b un=%b, want 1 0 0 1 0 0 0",
               bus.empty, bus.full, bus.count, bus.almost_empty, bus.almost_full,
               bus.overflow, bus.underflow);
    end
    checks++;
    if (bus.dout !== 32'd0) begin
      errors++;
      $display("FAIL reset_dout: got %0h want 0", bus.dout);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      write_word(32'(i));
      checks++;
      if (bus.count !== 5'(i) || bus.almost_full !== (i >= 14) || bus.full !== (i == 16) ||
          bus.empty !== 1'b0) begin
        errors++;
        $display("FAIL fill_%0d: count=%0d af=%b full=%b empty=%b, want %0d %b %b 0",
                 i, bus.count, bus.almost_full, bus.full, bus.empty, i, (i >= 14), (i == 16));
      end
    end
    write_word(32'hDEAD);
    checks++;
    if (bus.overflow !== 1'b1 || bus.count !== 5'd16 || bus.full !== 1'b1) begin
      errors++;
      $display("FAIL overflow_pulse: ov=%b count=%0d full=%b, want 1 16 1",
               bus.overflow, bus.count, bus.full);
    end
    step();
    checks++;
    if (bus.overflow !== 1'b0 || bus.count !== 5'd16) begin
      errors++;
      $display("FAIL overflow_clear: ov=%b count=%0d, want 0 16", bus.overflow, bus.count);
    end
  endtask

  task automatic test_drain();
    logic [31:0] obs;
    for (int i = 1; i <= 16; i++) begin
      read_word(1'b0, '0, obs);
      checks++;
      if (obs !== 32'(i) || bus.count !== 5'(16 - i) || bus.almost_empty !== (16 - i <= 2) ||
          bus.empty !== (i == 16) || bus.underflow !== 1'b0) begin
        errors++;
        $display("FAIL drain_%0d: dout=%0d count=%0d ae=%b empty=%b un=%b, want %0d %0d %b %b 0",
                 i, obs, bus.count, bus.almost_empty, bus.empty, bus.underflow,
                 i, 16 - i, (16 - i <= 2), (i == 16));
      end
    end
    read_word(1'b0, '0, obs);
    checks++;
    if (bus.underflow !== 1'b1 || bus.dout !== 32'd16 || bus.count !== 5'd0) begin
      errors++;
      $display("FAIL underflow_pulse: un=%b dout=%0d count=%0d, want 1 16 0",
               bus.underflow, bus.dout, bus.count);
    end
    step();
    checks++;
    if (bus.underflow !== 1'b0 || bus.dout !== 32'd16) begin
      errors++;
      $display("FAIL underflow_clear: un=%b dout=%0d, want 0 16", bus.underflow, bus.dout);
    end
  endtask

  task automatic test_concurrency();
    logic [31:0] obs;
    // Half full: rd+wr keeps count at 8 and FIFO order.
    for (int i = 0; i < 8; i++) write_word(32'(201 + i));
    for (int i = 0; i < 4; i++) begin
      read_word(1'b1, 32'(209 + i), obs);
      checks++;
      if (obs !== 32'(201 + i) || bus.count !== 5'd8) begin
        errors++;
        $display("FAIL conc_mid_%0d: dout=%0d count=%0d, want %0d 8", i, obs, bus.count, 201 + i);
      end
    end
    for (int i = 0; i < 8; i++) begin
      read_word(1'b0, '0, obs);
      checks++;
      if (obs !== 32'(205 + i)) begin
        errors++;
        $display("FAIL conc_mid_drain_%0d: dout=%0d want %0d", i, obs, 205 + i);
      end
    end
    // Full: rd+wr both accepted, full stays high.
    for (int i = 0; i < 16; i++) write_word(32'(301 + i));
    for (int i = 0; i < 4; i++) begin
      read_word(1'b1, 32'(317 + i), obs);
      checks++;
      if (obs !== 32'(301 + i) || bus.full !== 1'b1 || bus.count !== 5'd16 ||
          bus.overflow !== 1'b0) begin
        errors++;
        $display("FAIL conc_full_%0d: dout=%0d full=%b count=%0d ov=%b, want %0d 1 16 0",
                 i, obs, bus.full, bus.count, bus.overflow, 301 + i);
      end
    end
    for (int i = 0; i < 16; i++) begin
      read_word(1'b0, '0, obs);
      checks++;
      if (obs !== 32'(305 + i)) begin
        errors++;
        $display("FAIL conc_full_drain_%0d: dout=%0d want %0d", i, obs, 305 + i);
      end
    end
    // Empty: write accepted, read rejected.
    read_word(1'b1, 32'd400, obs);
    checks++;
    if (bus.underflow !== 1'b1 || bus.count !== 5'd1 || bus.empty !== 1'b0) begin
      errors++;
      $display("FAIL conc_empty: un=%b count=%0d empty=%b, want 1 1 0",
               bus.underflow, bus.count, bus.empty);
    end
    read_word(1'b0, '0, obs);
    checks++;
    if (obs !== 32'd400 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL conc_empty_read: dout=%0d empty=%b, want 400 1", obs, bus.empty);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] obs;
    for (int i = 0; i < 10; i++) write_word(32'(50 + i));
    for (int i = 0; i < 10; i++) begin
      read_word(1'b0, '0, obs);
      checks++;
      if (obs !== 32'(50 + i)) begin
        errors++;
        $display("FAIL wrap_a_%0d: dout=%0d want %0d", i, obs, 50 + i);
      end
    end
    for (int i = 0; i < 12; i++) write_word(32'(100 + i));
    checks++;
    if (bus.count !== 5'd12) begin
      errors++;
      $display("FAIL wrap_count: count=%0d want 12", bus.count);
    end
    for (int i = 0; i < 12; i++) begin
      read_word(1'b0, '0, obs);
      checks++;
      if (obs !== 32'(100 + i)) begin
        errors++;
        $display("FAIL wrap_b_%0d: dout=%0d want %0d", i, obs, 100 + i);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] obs;
    for (int i = 0; i < 5; i++) write_word(32'(600 + i));
    bus.din   = 32'd999;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    rst       = 1'b1;
    step();
    rst = 1'b0;
    idle();
    checks++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.count !== 5'd0 || bus.dout !== 32'd0 ||
        bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0 ||
        bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: empty=%b full=%b count=%0d dout=%0d ae=%b af=%b ov=%b un=%b",
               bus.empty, bus.full, bus.count, bus.dout, bus.almost_empty, bus.almost_full,
               bus.overflow, bus.underflow);
    end
    read_word(1'b0, '0, obs);
    checks++;
    if (bus.underflow !== 1'b1 || bus.dout !== 32'd0 || bus.count !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid_read: un=%b dout=%0d count=%0d, want 1 0 0",
               bus.underflow, bus.dout, bus.count);
    end
  endtask

`ifdef SORT_FIFO_FWFT_EN
  task automatic test_fwft();
    write_word(32'd7);
    checks++;
    if (bus.empty !== 1'b0 || bus.dout !== 32'd7 || bus.count !== 5'd1) begin
      errors++;
      $display("FAIL fwft_head: empty=%b dout=%0d count=%0d, want 0 7 1",
               bus.empty, bus.dout, bus.count);
    end
  endtask
`endif

  initial begin
    bus.din   = '0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_concurrency();
    test_wrap();
    test_reset_mid();
`ifdef SORT_FIFO_FWFT_EN
    test_fwft();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sort_sync_fifo.md
Name: sort_sync_fifo

Overview:
Parametrised single-clock FIFO for the sorting datapath. It buffers keys between sorter stages and the host-facing load/unload logic, and replaces the fixed 32-bit vendor FIFO. It adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty flags, and overflow/underflow error pulses. A compile-time first-word-fall-through (FWFT) read mode is available.

Parameters:
DATA_W, 32, data word width in bits
DEPTH, 16, number of entries; power of 2, at least 2
ALMOST_FULL_TH, DEPTH-2, almost_full asserts when count >= this value
ALMOST_EMPTY_TH, 2, almost_empty asserts when count <= this value

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
din  in  DATA_W  write data
wr_en  in  1  write request
full  out  1  no free entry
rd_en  in  1  read request (in FWFT mode: acknowledge/pop)
dout  out  DATA_W  read data
empty  out  1  no readable data
almost_full  out  1  count >= ALMOST_FULL_TH
almost_empty  out  1  count <= ALMOST_EMPTY_TH
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: write rejected
underflow  out  1  one-cycle pulse: read rejected

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: dout=0, empty=1, full=0, count=0, almost_empty=1, almost_full=0, overflow=0, underflow=0. Pointers=0. RAM contents are not cleared.
- Reset mid-operation: all contents are discarded on the first edge with rst=1. Any wr_en/rd_en in that cycle is ignored.
- Pointers: wr_ptr and rd_ptr are each $clog2(DEPTH)+1 bits and wrap naturally. The MSB distinguishes full from empty.
- Flags: full, empty and count are registered. almost_* are decoded from registered count, so they are glitch-free.
- Accepted write: wr_en && (!full || rd_accepted). Data is stored at wr_ptr and wr_ptr increments.
- Accepted read (standard mode): rd_en && !empty. dout takes mem[rd_ptr] on the next edge, i.e. 1-cycle latency. dout holds its value whenever no read is accepted.
- Write while full with no read: ignored. overflow=1 for exactly one cycle. Contents and count are unchanged.
- Read while empty: ignored. underflow=1 for one cycle. dout holds.
- Simultaneous read and write, 0<count<DEPTH: both accepted; count unchanged.
- Simultaneous read and write at full: both accepted; full stays 1.
- Simultaneous read and write at empty: write accepted, read rejected (underflow pulses). No bypass; count becomes 1.
- Count update: count_next = count + wr_acc - rd_acc.
  - empty_next = (count_next == 0)
  - full_next = (count_next == DEPTH)
- Ordering: strict first in, first out across any number of pointer wraps.

Optional Feature:
SORT_FIFO_FWFT_EN
- Defined:
  - dout is pre-fetched into an output register.
  - empty deasserts, and dout presents the head word, on the edge after the first write into an empty FIFO.
  - rd_en && !empty pops the word; the next word, if any, appears on the following edge with no bubble.
  - count includes the output-register word and never exceeds DEPTH.
  - When empty, dout holds the last popped value.
- Undefined: standard 1-cycle-latency read as above.
- Flags, count, overflow and underflow semantics are identical in both modes.

Decomposition:
- Shared package/header sort_fifo_pkg holds:
  - default DATA_W (32) and DEPTH (16) constants
  - the clog2-based width helpers for pointer and count width
  - the FWFT macro guard default.
- One sub-module, sort_fifo_ram: simple dual-port array, DEPTH x DATA_W, synchronous write, synchronous registered read.
- The top level holds pointers, count, flags and the FWFT output stage.

Test Plan:
1. Reset: assert rst for 2 cycles, then release -> empty=1, full=0, count=0, dout=0, almost_empty=1.
2. Fill (DATA_W=32, DEPTH=16): write 32'd1..32'd16 back to back.
   - Required: almost_full rises when count reaches 14; full=1 after the 16th edge; count=16.
   - Then write 32'hDEAD -> overflow pulses 1 cycle; count stays 16.
3. Drain: 16 reads -> dout = 1..16, each valid one cycle after its rd_en; empty=1 after the last read.
   - Then one more read -> underflow pulses; dout holds 16.
4. Concurrency:
   - At count=8, rd_en+wr_en for 4 cycles -> count stays 8 and order is preserved.
   - At full, the same stimulus -> full stays 1.
   - At empty, rd_en+wr_en -> underflow=1 and count becomes 1.
5. Wrap: write 10/read 10, then write 12 (values 100..111)/read 12 -> dout = 100..111 in order; pointers have wrapped.
6. Reset mid-operation at count=5 -> all reset values on the next edge. A following read gives underflow and no stale data.
   - With SORT_FIFO_FWFT_EN: a single write of 32'd7 -> empty=0 and dout=7 one edge later, before any rd_en.
